// File: rtl/vector_alu_issue_if.sv
// Issue / ALU / writeback bundle for vector_alu_issue.
//   slave  : issue stage side (in_* in, alu_* out, alu results in, wb_* out)
//   master : environment side (decode, vector_alu, writeback consumer)
// Vectors are NUM_LANES lanes of VEC_W bits, lane 0 in the low bits.
interface vector_alu_issue_if #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 32
);
  logic                             in_valid, in_ready;
  logic [4:0]                       in_op;
  logic [7:0]                       in_imm;
  logic [NUM_LANES-1:0][VEC_W-1:0]  in_v1, in_v2;
  logic [VEC_W-1:0]                 in_r1, in_r2;
  logic [4:0]                       in_vdst, in_rdst;
  logic                             in_wr_v, in_wr_r;

  logic                             alu_en;
  logic [4:0]                       alu_op;
  logic [7:0]                       alu_imm;
  logic [NUM_LANES-1:0][VEC_W-1:0]  alu_v1, alu_v2, alu_vout;
  logic [VEC_W-1:0]                 alu_r1, alu_r2, alu_rout;

  logic                             wb_valid, wb_ready;
  logic [4:0]                       wb_vdst, wb_rdst;
  logic                             wb_wr_v, wb_wr_r;
  logic [NUM_LANES-1:0][VEC_W-1:0]  wb_vdata;
  logic [VEC_W-1:0]                 wb_rdata;

  logic                             flush, busy;
  logic [1:0]                       inflight;

  modport slave (
    input  in_valid, in_op, in_imm, in_v1, in_v2, in_r1, in_r2,
           in_vdst, in_rdst, in_wr_v, in_wr_r,
           alu_vout, alu_rout, wb_ready, flush,
    output in_ready, alu_en, alu_op, alu_imm, alu_v1, alu_v2, alu_r1, alu_r2,
           wb_valid, wb_vdst, wb_rdst, wb_wr_v, wb_wr_r, wb_vdata, wb_rdata,
           busy, inflight
  );

  modport master (
    output in_valid, in_op, in_imm, in_v1, in_v2, in_r1, in_r2,
           in_vdst, in_rdst, in_wr_v, in_wr_r,
           alu_vout, alu_rout, wb_ready, flush,
    input  in_ready, alu_en, alu_op, alu_imm, alu_v1, alu_v2, alu_r1, alu_r2,
           wb_valid, wb_vdst, wb_rdst, wb_wr_v, wb_wr_r, wb_vdata, wb_rdata,
           busy, inflight
  );
endinterface

// File: rtl/vector_alu_issue.sv
// vector_alu_issue: issue stage in front of a 2-cycle vector_alu.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : vector_alu_issue_if.slave (issue handshake, ALU drive,
//                ALU results, writeback handshake, flush/busy/inflight)
// S0 holds the operands that drive the ALU; T1/T2 carry destination tags
// alongside the ALU pipeline so T2 lines up with alu_vout/alu_rout.
// The whole pipe freezes while T2 waits on wb_ready.

// Per-lane operand register of S0.
module vector_alu_issue_lane #(
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [VEC_W-1:0] d1,
  input  logic [VEC_W-1:0] d2,
  output logic [VEC_W-1:0] q1,
  output logic [VEC_W-1:0] q2
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q2 <= '0;
    end else if (en) begin
      q1 <= d1;
      q2 <= d2;
    end
  end
endmodule

module vector_alu_issue #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 32
) (
  input logic               clk,
  input logic               rst_n,
  vector_alu_issue_if.slave bus
);
  localparam int STAGES = 2;

  // op is consumed by the ALU only, so it lives in S0 and is not carried
  // down the tag stages.
  typedef struct packed {
    logic [4:0] vdst;
    logic [4:0] rdst;
    logic       wr_v;
    logic       wr_r;
  } tag_t;

  logic [STAGES:0]                 vld_pipe;   // [0]=S0, [1]=T1, [2]=T2
  tag_t [STAGES:0]                 tag_pipe;
  logic [4:0]                      s0_op;
  logic [7:0]                      s0_imm;
  logic [VEC_W-1:0]                s0_r1, s0_r2;
  logic [NUM_LANES-1:0][VEC_W-1:0] s0_v1, s0_v2;
  logic                            stall, alu_en, accept;
  tag_t                            in_tag;

  assign stall  = vld_pipe[STAGES] & ~bus.wb_ready;
  assign alu_en = ~stall;
  // rst_n gates ready so nothing is offered as accepted while in reset.
  assign bus.in_ready = alu_en & ~bus.flush & rst_n;
  assign accept = bus.in_valid & bus.in_ready;
  assign in_tag = '{vdst: bus.in_vdst, rdst: bus.in_rdst,
                    wr_v: bus.in_wr_v, wr_r: bus.in_wr_r};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vector_alu_issue_lane #(.VEC_W(VEC_W)) u_lane (
      .clk (clk),
      .rst_n (rst_n),
      .en  (accept),
      .d1  (bus.in_v1[l]),
      .d2  (bus.in_v2[l]),
      .q1  (s0_v1[l]),
      .q2  (s0_v2[l])
    );
  end

  // flush wins over stall and issue; a stall freezes every stage so the
  // tags stay aligned with the frozen ALU pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      s0_op    <= '0;
      s0_imm   <= '0;
      s0_r1    <= '0;
      s0_r2    <= '0;
    end else if (bus.flush) begin
      vld_pipe <= '0;
    end else if (alu_en) begin
      vld_pipe           <= {vld_pipe[STAGES-1:0], accept};
      tag_pipe[STAGES:1] <= tag_pipe[STAGES-1:0];
      if (accept) begin
        tag_pipe[0] <= in_tag;
        s0_op       <= bus.in_op;
        s0_imm      <= bus.in_imm;
        s0_r1       <= bus.in_r1;
        s0_r2       <= bus.in_r2;
      end
    end
  end

  assign bus.alu_en  = alu_en;
  assign bus.alu_op  = s0_op;
  assign bus.alu_imm = s0_imm;
  assign bus.alu_v1  = s0_v1;
  assign bus.alu_v2  = s0_v2;
  assign bus.alu_r1  = s0_r1;
  assign bus.alu_r2  = s0_r2;

  assign bus.wb_valid = vld_pipe[STAGES] & ~bus.flush;
  assign bus.wb_vdst  = tag_pipe[STAGES].vdst;
  assign bus.wb_rdst  = tag_pipe[STAGES].rdst;
  assign bus.wb_wr_v  = tag_pipe[STAGES].wr_v & bus.wb_valid;
  assign bus.wb_wr_r  = tag_pipe[STAGES].wr_r & bus.wb_valid;
  assign bus.wb_vdata = bus.alu_vout;
  assign bus.wb_rdata = bus.alu_rout;

  assign bus.inflight = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]};
  assign bus.busy     = |vld_pipe;
endmodule

// File: tb/tb_vector_alu_issue.sv
module tb_vector_alu_issue;
  typedef logic [3:0][31:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  vector_alu_issue_if bus ();
  vector_alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Positive normalised fp32 add (truncating); enough for the float vectors.
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex;
    logic [24:0] mx, my, s;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = x[30:23];
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]} >> (x[30:23] - y[30:23]);
    s  = mx + my;
    if (s[24]) begin s = s >> 1; ex = ex + 8'd1; end
    return {1'b0, ex, s[22:0]};
  endfunction

  function automatic vec_t vfun(logic [4:0] op, logic [7:0] imm, vec_t a, vec_t b);
    vec_t r;
    for (int i = 0; i < 4; i++)
      r[i] = (op == 5'h03) ? fadd(a[i], b[i]) : a[i] + (b[i] ^ {27'b0, op}) + {24'b0, imm};
    return r;
  endfunction

  // Stand-in vector_alu: two enabled stages.
  vec_t        a_v = '0, b_v = '0;
  logic [31:0] a_r = '0, b_r = '0;
  always @(posedge clk) begin
    if (bus.alu_en) begin
      a_v <= vfun(bus.alu_op, bus.alu_imm, bus.alu_v1, bus.alu_v2);
      a_r <= bus.alu_r1 + bus.alu_r2 + {24'b0, bus.alu_imm};
      b_v <= a_v;
      b_r <= a_r;
    end
  end
  assign bus.alu_vout = b_v;
  assign bus.alu_rout = b_r;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic smp(); @(negedge clk); endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  // Simple issue: op 1, lane i of v1 = tag*16+i, v2 = 0, imm 0.
  task automatic set_in(input bit iv, input logic [4:0] tag, input bit wr, input bit fl);
    bus.in_valid = iv;
    bus.in_op    = 5'h01;
    bus.in_imm   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bus.in_v1[i] = {27'b0, tag} * 32'd16 + 32'(i);
      bus.in_v2[i] = 32'h0;
    end
    bus.in_r1    = {27'b0, tag};
    bus.in_r2    = 32'h0;
    bus.in_vdst  = tag;
    bus.in_rdst  = tag;
    bus.in_wr_v  = 1'b1;
    bus.in_wr_r  = 1'b1;
    bus.wb_ready = wr;
    bus.flush    = fl;
  endtask

  // Result expected for set_in(tag): lane i = tag*16 + i + 1.
  function automatic vec_t vexp(logic [4:0] tag);
    vec_t r;
    for (int i = 0; i < 4; i++) r[i] = {27'b0, tag} * 32'd16 + 32'(i) + 32'd1;
    return r;
  endfunction

  typedef struct {
    bit iv; logic [4:0] tag; bit wr; bit fl;
    bit e_ir; bit e_wbv; logic [4:0] e_vd; logic [1:0] e_inf;
  } row_t;
  row_t tbl[16];

  typedef struct {
    logic [4:0] vdst, rdst; logic wv, wr; vec_t vd; logic [31:0] rd;
  } exp_t;
  exp_t q[$];

  initial begin
    vec_t v1, v2, ve;
    exp_t e;
    bit   hold;
    logic [4:0] pvd;
    vec_t pvv;

    // backpressure, flush with 3 in flight, then a lone op
    tbl[0]  = '{1, 1, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 2, 1, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, 3, 1, 0, 1, 0, 0, 2};
    tbl[3]  = '{1, 4, 0, 0, 0, 1, 1, 3};
    tbl[4]  = '{1, 4, 0, 0, 0, 1, 1, 3};
    tbl[5]  = '{1, 4, 0, 0, 0, 1, 1, 3};
    tbl[6]  = '{1, 4, 0, 0, 0, 1, 1, 3};
    tbl[7]  = '{1, 4, 1, 0, 1, 1, 1, 3};
    tbl[8]  = '{1, 5, 1, 0, 1, 1, 2, 3};
    tbl[9]  = '{1, 6, 1, 1, 0, 0, 0, 3};
    tbl[10] = '{0, 0, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 7, 1, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 1, 0, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 1, 0, 1, 1, 7, 1};
    tbl[15] = '{0, 0, 1, 0, 1, 0, 0, 0};

    rst_n = 1'b0;
    set_in(0, 0, 1, 0);
    bus.in_op = 5'h00;
    nxt(); nxt();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_alu_v1", bus.alu_v1, 0);
    chk("rst_alu_r1", bus.alu_r1, 0);
    chk("rst_alu_en", bus.alu_en, 1);
    rst_n = 1'b1;

    // single fp add op
    v1[0] = 32'h3F800000; v1[1] = 32'h40000000; v1[2] = 32'h40400000; v1[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) v2[i] = 32'h3F000000;
    ve[0] = 32'h3FC00000; ve[1] = 32'h40200000; ve[2] = 32'h40600000; ve[3] = 32'h40900000;
    set_in(1, 7, 1, 0);
    bus.in_op = 5'h03; bus.in_v1 = v1; bus.in_v2 = v2; bus.in_wr_r = 1'b0;
    smp(); chk("op_in_ready", bus.in_ready, 1);
    nxt(); set_in(0, 0, 1, 0);
    smp(); chk("op_s0_op", bus.alu_op, 5'h03); chk("op_s0_v1", bus.alu_v1, v1);
    chk("op_inflight1", bus.inflight, 1);
    nxt(); smp(); chk("op_wb_early", bus.wb_valid, 0);
    nxt(); smp();
    chk("op_wb_valid", bus.wb_valid, 1); chk("op_wb_vdst", bus.wb_vdst, 7);
    chk("op_wb_wr_v", bus.wb_wr_v, 1); chk("op_wb_wr_r", bus.wb_wr_r, 0);
    chk("op_wb_vdata", bus.wb_vdata, ve);
    nxt(); smp(); chk("op_wb_after", bus.wb_valid, 0); chk("op_idle", bus.inflight, 0);
    nxt();

    // table
    for (int r = 0; r < 16; r++) begin
      set_in(tbl[r].iv, tbl[r].tag, tbl[r].wr, tbl[r].fl);
      smp();
      chk($sformatf("tbl%0d_in_ready", r), bus.in_ready, tbl[r].e_ir);
      chk($sformatf("tbl%0d_wb_valid", r), bus.wb_valid, tbl[r].e_wbv);
      chk($sformatf("tbl%0d_wb_wr_v", r), bus.wb_wr_v, tbl[r].e_wbv);
      chk($sformatf("tbl%0d_inflight", r), bus.inflight, tbl[r].e_inf);
      if (tbl[r].e_wbv) begin
        chk($sformatf("tbl%0d_wb_vdst", r), bus.wb_vdst, tbl[r].e_vd);
        chk($sformatf("tbl%0d_wb_vdata", r), bus.wb_vdata, vexp(tbl[r].e_vd));
      end
      nxt();
    end

    // streaming 8 back-to-back
    for (int c = 0; c < 11; c++) begin
      set_in(c < 8, 5'(c), 1, 0);
      smp();
      chk($sformatf("strm%0d_wb_valid", c), bus.wb_valid, c >= 3);
      if (c >= 3) chk($sformatf("strm%0d_wb_vdst", c), bus.wb_vdst, 5'(c - 3));
      if (c >= 3 && c <= 7) chk($sformatf("strm%0d_inflight", c), bus.inflight, 3);
      nxt();
    end

    // alternating bubbles
    for (int c = 0; c < 12; c++) begin
      set_in((c % 2 == 0) && c < 8, 5'(c + 10), 1, 0);
      smp();
      chk($sformatf("bub%0d_wb_valid", c), bus.wb_valid, (c >= 3) && ((c - 3) % 2 == 0) && (c - 3) < 8);
      chk($sformatf("bub%0d_infl_le2", c), bus.inflight <= 2, 1);
      nxt();
    end

    // reset with three in flight
    for (int c = 0; c < 3; c++) begin set_in(1, 5'(c + 1), 1, 0); nxt(); end
    set_in(0, 0, 1, 0);
    smp(); chk("mrst_pre_infl", bus.inflight, 3);
    rst_n = 1'b0; #1;
    chk("mrst_inflight", bus.inflight, 0); chk("mrst_wb_valid", bus.wb_valid, 0);
    chk("mrst_busy", bus.busy, 0); chk("mrst_in_ready", bus.in_ready, 0);
    nxt(); rst_n = 1'b1;
    set_in(1, 9, 1, 0);
    smp(); chk("mrst_accept", bus.in_ready, 1);
    nxt(); set_in(0, 0, 1, 0);
    smp(); chk("mrst_wb1", bus.wb_valid, 0);
    nxt(); smp(); chk("mrst_wb2", bus.wb_valid, 0);
    nxt(); smp();
    chk("mrst_wb3", bus.wb_valid, 1); chk("mrst_vdst", bus.wb_vdst, 9);
    chk("mrst_vdata", bus.wb_vdata, vexp(9));
    nxt(); smp(); chk("mrst_idle", bus.inflight, 0);
    nxt();

    // randomized against a queue model
    hold = 0; pvd = '0; pvv = '0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.in_op    = 5'($urandom);
      bus.in_imm   = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        bus.in_v1[i] = $urandom; bus.in_v2[i] = $urandom;
      end
      bus.in_r1    = $urandom; bus.in_r2 = $urandom;
      bus.in_vdst  = 5'($urandom); bus.in_rdst = 5'($urandom);
      bus.in_wr_v  = 1'($urandom); bus.in_wr_r = 1'($urandom);
      bus.wb_ready = $urandom_range(0, 9) < 7;
      bus.flush    = $urandom_range(0, 19) == 0;
      smp();
      chk("rnd_inflight", bus.inflight, 128'(q.size()));
      chk("rnd_busy", bus.busy, q.size() != 0);
      if (!bus.wb_valid) chk("rnd_wr_qual", {bus.wb_wr_v, bus.wb_wr_r}, 0);
      if (hold && !bus.flush) begin
        chk("rnd_hold_valid", bus.wb_valid, 1);
        chk("rnd_hold_vdst", bus.wb_vdst, pvd);
        chk("rnd_hold_vdata", bus.wb_vdata, pvv);
      end
      if (bus.wb_valid && bus.wb_ready) begin
        if (q.size() == 0) chk("rnd_spurious_wb", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_wb_tags", {bus.wb_vdst, bus.wb_rdst, bus.wb_wr_v, bus.wb_wr_r},
              {e.vdst, e.rdst, e.wv, e.wr});
          chk("rnd_wb_vdata", bus.wb_vdata, e.vd);
          chk("rnd_wb_rdata", bus.wb_rdata, e.rd);
        end
      end
      if (bus.flush) q.delete();
      if (bus.in_valid && bus.in_ready) begin
        e.vdst = bus.in_vdst; e.rdst = bus.in_rdst; e.wv = bus.in_wr_v; e.wr = bus.in_wr_r;
        e.vd = vfun(bus.in_op, bus.in_imm, bus.in_v1, bus.in_v2);
        e.rd = bus.in_r1 + bus.in_r2 + {24'b0, bus.in_imm};
        q.push_back(e);
      end
      hold = bus.wb_valid && !bus.wb_ready;
      pvd  = bus.wb_vdst;
      pvv  = bus.wb_vdata;
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_alu_issue.md
VECTOR_ALU_ISSUE -- requirements
Module: vector_alu_issue

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: in_valid  in  1 / in_ready  out  1  issue handshake from decode.
REQ-004 SHALL provide: in_op  in  5 / in_imm  in  8 / in_v1, in_v2  in  4x32 / in_r1, in_r2  in  32  operation and operands.
REQ-005 SHALL provide: in_vdst, in_rdst  in  5 / in_wr_v, in_wr_r  in  1  destination tags and write enables.
REQ-006 SHALL provide: alu_en  out  1 / alu_op  out  5 / alu_imm  out  8 / alu_v1, alu_v2  out  4x32 / alu_r1, alu_r2  out  32  drive to vector_alu.
REQ-007 SHALL provide: alu_vout  in  4x32 / alu_rout  in  32  results from vector_alu.
REQ-008 SHALL provide: wb_valid  out  1 / wb_ready  in  1 / wb_vdst, wb_rdst  out  5 / wb_wr_v, wb_wr_r  out  1 / wb_vdata  out  4x32 / wb_rdata  out  32  writeback port.
REQ-009 SHALL provide: flush  in  1  synchronous kill of all in-flight ops / busy  out  1 / inflight  out  2  occupancy count.

Function
REQ-010 SHALL hold an operand stage S0 (registered, drives alu_* outputs) and tag stages T1, T2, each with a valid bit and tag fields {vdst, rdst, wr_v, wr_r, op}.
REQ-011 SHALL model vector_alu latency as 2 en-cycles: operands in S0 on cycle t with alu_en=1 at t and t+1 yield alu_vout/alu_rout valid on cycle t+2.
REQ-012 SHALL compute stall = T2.valid & ~wb_ready; alu_en = ~stall (combinational).
REQ-013 SHALL drive in_ready = alu_en & ~flush.
REQ-014 On posedge with alu_en=1: S0 <= accepted input (valid=1) if in_valid & in_ready, else S0.valid <= 0; T1 <= S0 tags/valid; T2 <= T1.
REQ-015 On posedge with alu_en=0: S0, T1, T2 SHALL hold unchanged; alu_* outputs stable.
REQ-016 SHALL drive wb_valid = T2.valid & ~flush; wb_vdata/wb_rdata = alu_vout/alu_rout; wb tags from T2.
REQ-017 A writeback retires when wb_valid & wb_ready; if not retired, wb outputs SHALL remain stable until retired or flushed.
REQ-018 flush=1 SHALL clear S0.valid, T1.valid, T2.valid on the next posedge, take priority over stall and issue, and accept no input that cycle.
REQ-019 inflight SHALL equal S0.valid + T1.valid + T2.valid (0..3, combinational); busy = (inflight != 0).
REQ-020 Back-to-back issue SHALL sustain one op per cycle with wb_ready held high; tags SHALL never reorder.
REQ-021 Bubbles (in_valid=0) SHALL propagate as invalid stages; no wb_valid pulse for a bubble.
REQ-022 Tag fields of invalid stages SHALL not affect outputs; wb_wr_v/wb_wr_r are qualified by wb_valid.

Reset
REQ-023 On rst_n=0 (asynchronous): all valid bits 0, all S0 operand/op/imm and tag registers 0.
REQ-024 During reset: in_ready=0, wb_valid=0, busy=0, inflight=0, alu_op=0, alu_v*/alu_r*=0; alu_en=1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight ops; first issue accepted on the first posedge after rst_n rises.

Verification
REQ-026 Single op: issue op=5'h03, v1={1.0,2.0,3.0,4.0}, v2={0.5,0.5,0.5,0.5} (float bits), vdst=7, wr_v=1 at cycle 0 -> S0 at cycle 1, wb_valid=1 at cycle 3 with wb_vdst=7, wb_vdata={1.5,2.5,3.5,4.5}.
REQ-027 Streaming: 8 consecutive issues with vdst=0..7, wb_ready=1 -> 8 consecutive wb_valid pulses, vdst 0..7 in order, inflight=3 in steady state.
REQ-028 Backpressure: wb_ready=0 for 4 cycles while T2 valid -> alu_en=0, in_ready=0, wb_* stable 4 cycles; no loss or duplication after release.
REQ-029 Flush: 3 ops in flight, flush=1 one cycle -> no wb_valid for them, inflight=0 next cycle, in_valid held high that cycle not accepted.
REQ-030 Reset mid-stream: rst_n=0 with inflight=3 -> immediate inflight=0, wb_valid=0; post-reset issue completes with correct 2-cycle latency.
REQ-031 Bubbles: alternating in_valid 1/0 -> wb_valid alternates 1/0 three cycles later, inflight never exceeds 2.
